// File: rtl/fifo_rd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_rd_seq                                                |
// | Description : Read sequencer for the multi-lane FIFO RAM buffer in the   |
// |               conv datapath. Tracks occupancy from write events and for  |
// |               each output pixel reads a kernel window (repeated for      |
// |               weight-reuse passes), then pops the stride.                |
// | Ports       : i_clk/i_rst_n   clock, async active-low reset              |
// |               i_flush         sync clear of occupancy, pointer and FSM   |
// |               i_start, i_cfg_* frame start and latched configuration     |
// |               i_wr            mirror of the buffer write strobes         |
// |               i_pe_ready      PE able to take data for a read            |
// |               o_read/o_raddr  buffer read strobe and address             |
// |               o_lastpix/o_pop buffer rewind and pop strobes              |
// |               o_occ/o_full    occupancy and upstream backpressure        |
// |               o_busy/o_done/o_err  status                                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module fifo_rd_seq #(
   parameter int SIZE  = 12,
   parameter int AWD   = $clog2(SIZE),
   parameter int RPWD  = 4,
   parameter int PIXWD = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_start,
   input  logic [AWD:0]     i_cfg_win,
   input  logic [RPWD-1:0]  i_cfg_reuse,
   input  logic [AWD:0]     i_cfg_stride,
   input  logic [PIXWD-1:0] i_cfg_npix,
   input  logic             i_wr,
   input  logic             i_pe_ready,
   output logic             o_read,
   output logic [AWD-1:0]   o_raddr,
   output logic             o_lastpix,
   output logic             o_pop,
   output logic [AWD:0]     o_occ,
   output logic             o_full,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   localparam logic [AWD:0]   C_SIZE = (AWD+1)'(SIZE);
   localparam logic [AWD-1:0] C_LAST = AWD'(SIZE-1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_READ = 3'd2,
      S_POP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [AWD:0]     occ_q, occ_d;
   logic [AWD-1:0]   start_q, start_d;
   logic [AWD-1:0]   idx_q, idx_d;       // next window entry to issue
   logic [AWD-1:0]   ridx_q, ridx_d;     // window entry currently presented
   logic [RPWD-1:0]  pass_q, pass_d;
   logic [PIXWD-1:0] pix_q, pix_d;
   logic [AWD:0]     popcnt_q, popcnt_d;
   logic             fin_q, fin_d;       // presenting the final read of a pixel
   logic [AWD:0]     win_q, win_d;
   logic [RPWD-1:0]  reuse_q, reuse_d;
   logic [AWD:0]     stride_q, stride_d;
   logic [PIXWD-1:0] npix_q, npix_d;
   logic             read_q, read_d;
   logic             lastpix_q, lastpix_d;
   logic             pop_q, pop_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             full_q, full_d;
   logic             issue_en;
   logic             cfg_bad;
   logic [PIXWD-1:0] pix_inc;
   logic [AWD:0]     raddr_sum;

   assign cfg_bad = (i_cfg_win == '0) || (i_cfg_reuse == '0) || (i_cfg_stride == '0) ||
                    (i_cfg_npix == '0) || (i_cfg_win > C_SIZE) || (i_cfg_stride > i_cfg_win);
   assign pix_inc = pix_q + 1'b1;

   // Outputs are registered one cycle ahead: every *_d strobe computed here is
   // what the buffer sees during the next cycle, so the issue decision for a
   // read is taken (with i_pe_ready) in the cycle before the strobe appears.
   always_comb begin
      state_d   = state_q;
      occ_d     = occ_q;
      start_d   = start_q;
      idx_d     = idx_q;
      ridx_d    = ridx_q;
      pass_d    = pass_q;
      pix_d     = pix_q;
      popcnt_d  = popcnt_q;
      fin_d     = fin_q;
      win_d     = win_q;
      reuse_d   = reuse_q;
      stride_d  = stride_q;
      npix_d    = npix_q;
      read_d    = 1'b0;
      lastpix_d = 1'b0;
      pop_d     = 1'b0;
      done_d    = 1'b0;
      err_d     = err_q;
      issue_en  = 1'b0;

      // A write at full is flagged and dropped; write+pop leaves occ unchanged.
      if (i_wr && occ_q == C_SIZE) begin
         err_d = 1'b1;
      end
      if (i_wr && !pop_q && occ_q != C_SIZE) begin
         occ_d = occ_q + 1'b1;
      end else if (!i_wr && pop_q) begin
         occ_d = occ_q - 1'b1;
      end
      if (pop_q) begin
         start_d = (start_q == C_LAST) ? '0 : start_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               win_d    = i_cfg_win;
               reuse_d  = i_cfg_reuse;
               stride_d = i_cfg_stride;
               npix_d   = i_cfg_npix;
               idx_d    = '0;
               pass_d   = '0;
               pix_d    = '0;
               fin_d    = 1'b0;
               if (cfg_bad) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (occ_q >= win_q) begin
               state_d  = S_READ;
               issue_en = 1'b1;
            end
         end
         S_READ: begin
            if (fin_q) begin
               fin_d    = 1'b0;
               state_d  = S_POP;
               pop_d    = 1'b1;
               popcnt_d = (AWD+1)'(1);
            end else begin
               issue_en = 1'b1;
            end
         end
         S_POP: begin
            if (popcnt_q == stride_q) begin
               pix_d = pix_inc;
               if (pix_inc == npix_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               pop_d    = 1'b1;
               popcnt_d = popcnt_q + 1'b1;
            end
         end
         S_DONE: begin
            pix_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (issue_en && i_pe_ready) begin
         read_d = 1'b1;
         ridx_d = idx_q;
         if ({1'b0, idx_q} == (win_q - 1'b1)) begin
            idx_d = '0;
            if (pass_q < (reuse_q - 1'b1)) begin
               lastpix_d = 1'b1;
               pass_d    = pass_q + 1'b1;
            end else begin
               pass_d = '0;
               fin_d  = 1'b1;
            end
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      if (i_flush) begin
         state_d   = S_IDLE;
         occ_d     = '0;
         start_d   = '0;
         idx_d     = '0;
         ridx_d    = '0;
         pass_d    = '0;
         pix_d     = '0;
         popcnt_d  = '0;
         fin_d     = 1'b0;
         read_d    = 1'b0;
         lastpix_d = 1'b0;
         pop_d     = 1'b0;
         done_d    = 1'b0;
         err_d     = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
      full_d = (occ_d == C_SIZE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         occ_q     <= '0;
         start_q   <= '0;
         idx_q     <= '0;
         ridx_q    <= '0;
         pass_q    <= '0;
         pix_q     <= '0;
         popcnt_q  <= '0;
         fin_q     <= 1'b0;
         win_q     <= '0;
         reuse_q   <= '0;
         stride_q  <= '0;
         npix_q    <= '0;
         read_q    <= 1'b0;
         lastpix_q <= 1'b0;
         pop_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         occ_q     <= occ_d;
         start_q   <= start_d;
         idx_q     <= idx_d;
         ridx_q    <= ridx_d;
         pass_q    <= pass_d;
         pix_q     <= pix_d;
         popcnt_q  <= popcnt_d;
         fin_q     <= fin_d;
         win_q     <= win_d;
         reuse_q   <= reuse_d;
         stride_q  <= stride_d;
         npix_q    <= npix_d;
         read_q    <= read_d;
         lastpix_q <= lastpix_d;
         pop_q     <= pop_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         full_q    <= full_d;
      end
   end

   // Address wraps modulo the FIFO depth, which need not be a power of two.
   assign raddr_sum = {1'b0, start_q} + {1'b0, ridx_q};
   assign o_raddr   = AWD'((raddr_sum >= C_SIZE) ? (raddr_sum - C_SIZE) : raddr_sum);

   assign o_read    = read_q;
   assign o_lastpix = lastpix_q;
   assign o_pop     = pop_q;
   assign o_occ     = occ_q;
   assign o_full    = full_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_err     = err_q;

endmodule
`default_nettype wire
